// File: rtl/cmp_pkg.sv
// ============================================================================
// cmp_pkg : shared encodings for the chunked comparator sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

  localparam logic [2:0] CMP_GT  = 3'b100;
  localparam logic [2:0] CMP_EQ  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b001;
  localparam int         SLICE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/compare_16bits.sv
// ============================================================================
// compare_16bits : one 16-bit comparator slice; a differing chunk decides,
//                  an equal chunk passes the lower-order pre_result through.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module compare_16bits
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [2:0]         pre_result,
  output logic [2:0]         result
);

  always_comb begin
    result = pre_result;
    if (a > b) begin
      result = CMP_GT;
    end else if (a < b) begin
      result = CMP_LT;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmp_seq_ctrl.sv
// ============================================================================
// cmp_seq_ctrl : multi-cycle WIDTH-bit compare on one shared 16-bit slice,
//                LSB chunk first. Optional macro SIGNED_CMP_EN adds is_signed.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SIGNED_CMP_EN
  input  logic             is_signed,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       result,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / SLICE_W;
  localparam int CW     = $clog2(NCHUNK);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           acc_q, acc_d;
  logic [2:0]           result_q, result_d;
  logic                 out_valid_q, out_valid_d;

  logic [NCHUNK-1:0][SLICE_W-1:0] a_chunks;
  logic [NCHUNK-1:0][SLICE_W-1:0] b_chunks;
  logic [2:0]                     slice_res;
  logic [WIDTH-1:0]               sign_mask;

  assign a_chunks = a_q;
  assign b_chunks = b_q;

`ifdef SIGNED_CMP_EN
  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign sign_mask = {is_signed, {(WIDTH-1){1'b0}}};
`else
  assign sign_mask = '0;
`endif

  compare_16bits u_slice (
    .a          (a_chunks[cnt_q]),
    .b          (b_chunks[cnt_q]),
    .pre_result (acc_q),
    .result     (slice_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= CMP_EQ;
      result_q    <= CMP_EQ;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a ^ sign_mask;
          b_d     = in_b ^ sign_mask;
          cnt_d   = '0;
          acc_d   = CMP_EQ;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = slice_res;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CHUNK) begin
          result_d    = slice_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // A same-cycle in_valid is deliberately left for the next IDLE cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

`default_nettype wire
